lfsr_gen: RTL and testbench
===========================

// Module: lfsr_gen
// PURPOSE
//   Parametrised LFSR pattern generator: Fibonacci or Galois, any width, runtime seed load.
//   Adds enable, all-zero lockup recovery and period measurement.
//   Feeds BIST/scrambler stimulus and test benches needing repeatable pseudo-random words.
// PARAMETERS
//   WIDTH   4        state width in bits, 2..32
//   TAPS    4'b1100  feedback mask, WIDTH bits (meaning depends on GALOIS)
//   GALOIS  0        0 = Fibonacci (XOR of tapped bits into bit0), 1 = Galois (internal XOR)
//   SEED    4'b0001  reset / recovery state; must be non-zero
// PORTS
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous, active-low reset
//   en           in   1      advance one step this cycle
//   load         in   1      load load_value this cycle (priority over en)
//   load_value   in   WIDTH  seed to load
//   shift_value  out  WIDTH  current LFSR state (registered)
//   out_bit      out  1      serial output = shift_value[WIDTH-1]
//   step_count   out  WIDTH  steps taken since last reset/load/period wrap
//   period_len   out  WIDTH  length of last completed period; 0 until first wrap
//   period_done  out  1      one-cycle pulse: state returned to start value
//   lockup       out  1      one-cycle pulse: zero state/seed detected, SEED substituted
// BEHAVIOUR
//   Reset (reset=0, async): shift_value=SEED, start=SEED, step_count=0, period_len=0,
//     period_done=0, lockup=0. Release is synchronous to clk; first step on first en after release.
//   Step function, state q (shift-left):
//     GALOIS=0: fb = ^(q & TAPS); next = {q[WIDTH-2:0], fb}
//     GALOIS=1: next = {q[WIDTH-2:0],1'b0} ^ (q[WIDTH-1] ? TAPS : 0)
//   Priority per cycle: load > en > hold. Latency: shift_value updates on the clk edge sampling the request.
//   load=1: shift_value<=load_value, start<=load_value, step_count<=0, period_done<=0.
//     load_value==0 -> shift_value<=SEED, start<=SEED, lockup<=1 for that cycle.
//   en=1 (no load):
//     q==0 (corruption) -> shift_value<=SEED, start<=SEED, step_count<=0, lockup<=1; no period_done.
//     else shift_value<=next; if next==start: period_done<=1, period_len<=step_count+1, step_count<=0;
//     otherwise step_count<=step_count+1 (wraps modulo 2^WIDTH; cannot overflow for max-length taps).
//   en=0, load=0: all state holds; period_done and lockup return to 0.
//   period_done and lockup are never asserted for more than one consecutive cycle
//     unless the triggering event repeats.
//   Simultaneous load and en: load wins, no step taken.
//   Reset mid-operation: all outputs return to reset values immediately (async), regardless of en/load.
//   Non-maximal TAPS allowed; period_len then reports the actual cycle length.
// TESTING
//   1 reset=0 two cycles then 1, en=1, defaults: shift_value 0001,0010,0100,1001,0011,0110,
//     1101,1010,0101,1011,0111,1111,1110,1100,1000,0001; period_done on 15th step, period_len=15.
//   2 GALOIS=1, TAPS=4'b0011, SEED=0001, en=1: 0010,0100,1000,0011,... ; period_len=15 after wrap.
//   3 load=1 load_value=4'b0000 -> shift_value=0001, lockup pulses 1 cycle, step_count=0.
//   4 load=1 and en=1 same cycle with load_value=1010 -> shift_value=1010 (no step);
//     then en for 15 cycles -> period_done as state returns to 1010, period_len=15.
//   5 en toggled 1,0,0,1 from SEED -> 0010 held two cycles, then 0100; step_count 1,1,1,2.
//   6 reset asserted mid-sequence (shift_value=0110) between edges -> outputs go to
//     reset values immediately; WIDTH=8, TAPS=8'b10111000 run gives period_len=255.

Source files
------------

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci/Galois LFSR pattern generator.
// Supports step enable, runtime seed load, all-zero lockup recovery and
// measurement of the cycle length back to the most recent start state.
module lfsr_gen #(
    parameter int unsigned      WIDTH  = 4,
    parameter logic [WIDTH-1:0] TAPS   = 4'b1100,
    parameter bit               GALOIS = 1'b0,
    parameter logic [WIDTH-1:0] SEED   = 4'b0001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] shift_value,
    output logic             out_bit,
    output logic [WIDTH-1:0] step_count,
    output logic [WIDTH-1:0] period_len,
    output logic             period_done,
    output logic             lockup
);

    // State the sequence started from; a period completes when we return here.
    logic [WIDTH-1:0] start_value;
    logic [WIDTH-1:0] next_value;
    logic [WIDTH-1:0] step_inc;
    logic             fib_fb;

    // Serial output is the MSB of the current state.
    assign out_bit  = shift_value[WIDTH-1];
    assign step_inc = step_count + WIDTH'(1);

    // Combinational one-step successor of the current state.
    always_comb begin
        next_value = '0;
        fib_fb     = 1'b0;
        if (GALOIS) begin
            next_value = {shift_value[WIDTH-2:0], 1'b0}
                       ^ (shift_value[WIDTH-1] ? TAPS : '0);
        end else begin
            fib_fb     = ^(shift_value & TAPS);
            next_value = {shift_value[WIDTH-2:0], fib_fb};
        end
    end

    // State register, period tracking and one-cycle status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_value <= SEED;
            start_value <= SEED;
            step_count  <= '0;
            period_len  <= '0;
            period_done <= 1'b0;
            lockup      <= 1'b0;
        end else begin
            // Pulses default low so they never stretch beyond one cycle.
            period_done <= 1'b0;
            lockup      <= 1'b0;
            if (load) begin
                step_count <= '0;
                if (load_value == '0) begin
                    // A zero seed would lock the LFSR; substitute SEED.
                    shift_value <= SEED;
                    start_value <= SEED;
                    lockup      <= 1'b1;
                end else begin
                    shift_value <= load_value;
                    start_value <= load_value;
                end
            end else if (en) begin
                if (shift_value == '0) begin
                    // Corrupted into the all-zero state: recover to SEED.
                    shift_value <= SEED;
                    start_value <= SEED;
                    step_count  <= '0;
                    lockup      <= 1'b1;
                end else begin
                    shift_value <= next_value;
                    if (next_value == start_value) begin
                        period_done <= 1'b1;
                        period_len  <= step_inc;
                        step_count  <= '0;
                    end else begin
                        step_count <= step_inc;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed bench for lfsr_gen covering Fibonacci, Galois and
// 8-bit configurations, seed load, lockup recovery and async reset.
module tb_lfsr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 4-bit Fibonacci instance (default parameters)
    logic       rst_a, en_a, load_a, ob_a, pd_a, lk_a;
    logic [3:0] lv_a, sv_a, sc_a, pl_a;
    // 4-bit Galois instance
    logic       rst_g, en_g, load_g, ob_g, pd_g, lk_g;
    logic [3:0] lv_g, sv_g, sc_g, pl_g;
    // 8-bit Fibonacci instance
    logic       rst_w, en_w, load_w, ob_w, pd_w, lk_w;
    logic [7:0] lv_w, sv_w, sc_w, pl_w;

    lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .GALOIS(1'b0), .SEED(4'b0001)) u_fib (
        .clk(clk), .reset(rst_a), .en(en_a), .load(load_a), .load_value(lv_a),
        .shift_value(sv_a), .out_bit(ob_a), .step_count(sc_a), .period_len(pl_a),
        .period_done(pd_a), .lockup(lk_a)
    );

    lfsr_gen #(.WIDTH(4), .TAPS(4'b0011), .GALOIS(1'b1), .SEED(4'b0001)) u_gal (
        .clk(clk), .reset(rst_g), .en(en_g), .load(load_g), .load_value(lv_g),
        .shift_value(sv_g), .out_bit(ob_g), .step_count(sc_g), .period_len(pl_g),
        .period_done(pd_g), .lockup(lk_g)
    );

    lfsr_gen #(.WIDTH(8), .TAPS(8'b10111000), .GALOIS(1'b0), .SEED(8'h01)) u_w8 (
        .clk(clk), .reset(rst_w), .en(en_w), .load(load_w), .load_value(lv_w),
        .shift_value(sv_w), .out_bit(ob_w), .step_count(sc_w), .period_len(pl_w),
        .period_done(pd_w), .lockup(lk_w)
    );

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if (sv_a !== 4'b0001) begin errors++; $display("FAIL reset_shift got %b exp 0001", sv_a); end
        checks++;
        if ({sc_a, pl_a, pd_a, lk_a, ob_a} !== 11'b0) begin
            errors++;
            $display("FAIL reset_status got sc=%0d pl=%0d pd=%b lk=%b ob=%b exp all 0", sc_a, pl_a, pd_a, lk_a, ob_a);
        end
        rst_a = 1'b1;
        rst_g = 1'b1;
        rst_w = 1'b1;
        tick();
        checks++;
        if (sv_a !== 4'b0001) begin errors++; $display("FAIL hold_after_release got %b exp 0001", sv_a); end
    endtask

    task automatic test_fib_sequence();
        logic [3:0] exp_seq [15] = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110,
                                     4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0111,
                                     4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};
        logic [3:0] e;
        en_a = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            e = exp_seq[i];
            checks++;
            if (sv_a !== e || ob_a !== e[3]) begin
                errors++;
                $display("FAIL fib_step%0d got %b/%b exp %b/%b", i + 1, sv_a, ob_a, e, e[3]);
            end
            checks++;
            if (pd_a !== (i == 14)) begin
                errors++;
                $display("FAIL fib_pd_step%0d got %b exp %b", i + 1, pd_a, (i == 14));
            end
            checks++;
            if (sc_a !== ((i == 14) ? 4'd0 : 4'(i + 1))) begin
                errors++;
                $display("FAIL fib_count_step%0d got %0d exp %0d", i + 1, sc_a, (i == 14) ? 0 : i + 1);
            end
        end
        checks++;
        if (pl_a !== 4'd15) begin errors++; $display("FAIL fib_period_len got %0d exp 15", pl_a); end
        en_a = 1'b0;
        tick();
        checks++;
        if (pd_a !== 1'b0 || sv_a !== 4'b0001) begin
            errors++;
            $display("FAIL fib_pulse_end got pd=%b sv=%b exp pd=0 sv=0001", pd_a, sv_a);
        end
    endtask

    task automatic test_galois();
        logic [3:0] exp_seq [15] = '{4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0110,
                                     4'b1100, 4'b1011, 4'b0101, 4'b1010, 4'b0111,
                                     4'b1110, 4'b1111, 4'b1101, 4'b1001, 4'b0001};
        en_g = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if (sv_g !== exp_seq[i]) begin
                errors++;
                $display("FAIL gal_step%0d got %b exp %b", i + 1, sv_g, exp_seq[i]);
            end
        end
        checks++;
        if (pd_g !== 1'b1 || pl_g !== 4'd15) begin
            errors++;
            $display("FAIL gal_period got pd=%b len=%0d exp pd=1 len=15", pd_g, pl_g);
        end
        en_g = 1'b0;
    endtask

    task automatic test_load_zero();
        en_a = 1'b1;
        tick();
        tick();
        en_a   = 1'b0;
        load_a = 1'b1;
        lv_a   = 4'b0000;
        tick();
        checks++;
        if (sv_a !== 4'b0001 || lk_a !== 1'b1 || sc_a !== 4'd0) begin
            errors++;
            $display("FAIL load_zero got sv=%b lk=%b sc=%0d exp sv=0001 lk=1 sc=0", sv_a, lk_a, sc_a);
        end
        load_a = 1'b0;
        tick();
        checks++;
        if (lk_a !== 1'b0 || sv_a !== 4'b0001) begin
            errors++;
            $display("FAIL lockup_pulse got lk=%b sv=%b exp lk=0 sv=0001", lk_a, sv_a);
        end
    endtask

    task automatic test_load_priority();
        load_a = 1'b1;
        en_a   = 1'b1;
        lv_a   = 4'b1010;
        tick();
        checks++;
        if (sv_a !== 4'b1010 || sc_a !== 4'd0 || lk_a !== 1'b0) begin
            errors++;
            $display("FAIL load_over_en got sv=%b sc=%0d lk=%b exp sv=1010 sc=0 lk=0", sv_a, sc_a, lk_a);
        end
        load_a = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if (pd_a !== (i == 14)) begin
                errors++;
                $display("FAIL load_period_pd_step%0d got %b exp %b", i + 1, pd_a, (i == 14));
            end
        end
        checks++;
        if (sv_a !== 4'b1010 || pl_a !== 4'd15) begin
            errors++;
            $display("FAIL load_period got sv=%b len=%0d exp sv=1010 len=15", sv_a, pl_a);
        end
        en_a = 1'b0;
    endtask

    task automatic test_en_toggle();
        logic       en_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] exp_sv [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
        logic [3:0] exp_sc [4] = '{4'd1, 4'd1, 4'd1, 4'd2};
        load_a = 1'b1;
        lv_a   = 4'b0001;
        tick();
        load_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            en_a = en_pat[i];
            tick();
            checks++;
            if (sv_a !== exp_sv[i] || sc_a !== exp_sc[i]) begin
                errors++;
                $display("FAIL en_toggle%0d got sv=%b sc=%0d exp sv=%b sc=%0d", i, sv_a, sc_a, exp_sv[i], exp_sc[i]);
            end
        end
        en_a = 1'b0;
    endtask

    task automatic test_reset_async();
        load_a = 1'b1;
        lv_a   = 4'b0001;
        tick();
        load_a = 1'b0;
        en_a   = 1'b1;
        repeat (5) tick();
        checks++;
        if (sv_a !== 4'b0110) begin errors++; $display("FAIL pre_reset_state got %b exp 0110", sv_a); end
        #2;
        rst_a = 1'b0;
        #1;
        checks++;
        if (sv_a !== 4'b0001 || sc_a !== 4'd0 || pl_a !== 4'd0 || pd_a !== 1'b0 || lk_a !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got sv=%b sc=%0d pl=%0d pd=%b lk=%b exp 0001/0/0/0/0", sv_a, sc_a, pl_a, pd_a, lk_a);
        end
        tick();
        en_a  = 1'b0;
        rst_a = 1'b1;
        tick();
        checks++;
        if (sv_a !== 4'b0001) begin errors++; $display("FAIL post_reset_hold got %b exp 0001", sv_a); end
    endtask

    task automatic test_width8_period();
        logic [7:0] first [4] = '{8'h02, 8'h04, 8'h08, 8'h11};
        int steps = 0;
        en_w = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            steps++;
            checks++;
            if (sv_w !== first[i]) begin
                errors++;
                $display("FAIL w8_step%0d got %h exp %h", i + 1, sv_w, first[i]);
            end
        end
        while (pd_w !== 1'b1 && steps < 600) begin
            tick();
            steps++;
        end
        checks++;
        if (pd_w !== 1'b1 || steps != 255) begin
            errors++;
            $display("FAIL w8_wrap got pd=%b at step %0d exp pd=1 at step 255", pd_w, steps);
        end
        checks++;
        if (pl_w !== 8'd255 || sv_w !== 8'h01) begin
            errors++;
            $display("FAIL w8_period got len=%0d sv=%h exp len=255 sv=01", pl_w, sv_w);
        end
        en_w = 1'b0;
    endtask

    initial begin
        rst_a = 1'b0; en_a = 1'b0; load_a = 1'b0; lv_a = '0;
        rst_g = 1'b0; en_g = 1'b0; load_g = 1'b0; lv_g = '0;
        rst_w = 1'b0; en_w = 1'b0; load_w = 1'b0; lv_w = '0;
        test_reset();
        test_fib_sequence();
        test_galois();
        test_load_zero();
        test_load_priority();
        test_en_toggle();
        test_reset_async();
        test_width8_period();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
